imm_decode_ctrl: RTL and testbench
==================================

// Module: imm_decode_ctrl
// PURPOSE
//  ID-stage immediate controller for the pipelined RV32I core.
//  - Accepts fetched instructions over a valid/ready handshake and decodes opcode to an immediate format.
//  - Forms the sign-extended immediate through an internal format unit.
//  - Holds the result in a 2-entry skid buffer feeding the ID/EX register, so EX back-pressure never drops an instruction.
// PARAMETERS
//  XLEN      32  datapath width; immediates are sign-extended to XLEN
//  SEL_W     3   width of the immediate-select code
// PORTS
//  CLK          in   1     rising-edge clock
//  RESET        in   1     asynchronous, active-high reset
//  FLUSH        in   1     branch/jump redirect; kill all buffered entries
//  IF_VALID     in   1     INSTRUCTION/PC valid from IF
//  IF_READY     out  1     block can accept this cycle
//  INSTRUCTION  in   32    raw instruction word
//  PC           in   XLEN  PC of INSTRUCTION
//  EX_VALID     out  1     EX_* outputs valid
//  EX_READY     in   1     EX consumes head entry this cycle
//  EX_IMM       out  XLEN  selected, sign-extended immediate
//  EX_IMM_SEL   out  SEL_W 0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J
//  EX_PC        out  XLEN  PC travelling with the entry
//  EX_ILLEGAL   out  1     unknown opcode (IMM_ILLEGAL_TRAP_EN only)
// BEHAVIOUR
//  - Reset (async): all EX_* outputs 0, IF_READY 1, occupancy 0.
//  - Opcode map, INSTRUCTION[6:0]:
//      0110111/0010111 -> U; 1101111 -> J; 1100111/0000011/0010011 -> I
//      0100011 -> S; 1100011 -> B; 0110011 -> NONE (imm 0); anything else -> NONE.
//  - Immediate formats:
//      I {{21{i31}},i[30:20]}; S {{21{i31}},i[30:25],i[11:7]}
//      B {{20{i31}},i[7],i[30:25],i[11:8],1'b0}; U {i[31:12],12'b0}
//      J {{12{i31}},i[19:12],i[20],i[30:21],1'b0}
//  - Accept = IF_VALID & IF_READY. Pop = EX_VALID & EX_READY.
//  - Latency: accepted instruction appears on EX_* the next cycle.
//  - Occupancy FSM: EMPTY / ONE / FULL (head = output register, skid = second entry).
//      EMPTY: accept -> ONE.
//      ONE: accept&!pop -> FULL (to skid); pop&!accept -> EMPTY; accept&pop -> ONE (head reloads).
//      FULL: pop -> ONE (skid moves to head); no accept possible.
//  - IF_READY = (state != FULL); registered, never combinationally dependent on EX_READY.
//  - EX_VALID = (state != EMPTY); EX_* stable while EX_VALID & !EX_READY.
//  - FLUSH has priority over accept and pop in the same cycle:
//      next state EMPTY; EX_VALID 0 next cycle; EX_IMM/EX_IMM_SEL/EX_PC/EX_ILLEGAL cleared to 0.
//  - RESET asserted mid-transfer discards all entries; nothing is replayed.
// CONFIGURATION
//  - IMM_ILLEGAL_TRAP_EN defined: an unknown opcode sets EX_ILLEGAL=1 with imm 0, carried with the entry.
//  - Not defined: EX_ILLEGAL tied 0; unknown opcode is treated as NONE.
// STRUCTURE
//  - Shared package imm_pkg:
//      imm_sel_t enum (NONE..J); opcode constants OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR,
//      OPC_LOAD, OPC_OPIMM, OPC_STORE, OPC_BRANCH, OPC_OP.
//  - One combinational sub-module, imm_format_unit: instruction -> five formatted immediates.
//    The opcode mux, FSM and skid buffer live in imm_decode_ctrl.
// TESTING
//  - 0xFFF00093 (addi x1,x0,-1), EX_READY=1 -> next cycle EX_IMM_SEL=1, EX_IMM=0xFFFFFFFF.
//  - 0x12345037 (lui) then 0xFE000EE3 (beq -4) -> EX_IMM 0x12345000 sel 4, then 0xFFFFFFFC sel 3.
//  - 0x0020A423 (sw x2,8(x1)) with EX_READY=0 for 3 cycles, next word 0x00000033 (add):
//      EX_IMM holds 0x00000008 sel 2; IF_READY falls after the 2nd accept;
//      add drains next with sel 0, imm 0; no loss, no duplicate.
//  - FULL state, FLUSH=1 with IF_VALID=1 and EX_READY=1 -> next cycle EX_VALID=0, IF_READY=1, FLUSH-cycle instr dropped.
//  - RESET pulse while FULL -> EX_VALID=0 and EX_IMM=0 immediately (async); IF_READY=1.
//  - Opcode 0x7F with IMM_ILLEGAL_TRAP_EN -> EX_ILLEGAL=1, imm 0; without the macro -> EX_ILLEGAL=0, sel 0.

Source files
------------

// File: rtl/imm_pkg.sv
// Shared immediate-select encoding, RV32I opcode constants and the
// opcode-to-format decode used by the ID-stage immediate controller.
package imm_pkg;

    typedef enum logic [2:0] {
        IMM_NONE = 3'd0,
        IMM_I    = 3'd1,
        IMM_S    = 3'd2,
        IMM_B    = 3'd3,
        IMM_U    = 3'd4,
        IMM_J    = 3'd5
    } imm_sel_t;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_state_t;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    function automatic imm_sel_t opcode_to_sel(input logic [6:0] opc);
        imm_sel_t sel;
        case (opc)
            OPC_LUI, OPC_AUIPC:           sel = IMM_U;
            OPC_JAL:                      sel = IMM_J;
            OPC_JALR, OPC_LOAD, OPC_OPIMM: sel = IMM_I;
            OPC_STORE:                    sel = IMM_S;
            OPC_BRANCH:                   sel = IMM_B;
            default:                      sel = IMM_NONE;
        endcase
        return sel;
    endfunction

    function automatic logic opcode_known(input logic [6:0] opc);
        logic known;
        case (opc)
            OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_LOAD,
            OPC_OPIMM, OPC_STORE, OPC_BRANCH, OPC_OP: known = 1'b1;
            default:                                  known = 1'b0;
        endcase
        return known;
    endfunction

endpackage

// File: rtl/imm_format_unit.sv
// Purely combinational: builds all five RV32I immediate formats from one
// instruction word and sign-extends each to XLEN.
module imm_format_unit #(
    parameter int XLEN = 32
) (
    input  logic [31:0]     i_instr,
    output logic [XLEN-1:0] o_imm_i,
    output logic [XLEN-1:0] o_imm_s,
    output logic [XLEN-1:0] o_imm_b,
    output logic [XLEN-1:0] o_imm_u,
    output logic [XLEN-1:0] o_imm_j
);

    logic signed [31:0] w_imm_i32;
    logic signed [31:0] w_imm_s32;
    logic signed [31:0] w_imm_b32;
    logic signed [31:0] w_imm_u32;
    logic signed [31:0] w_imm_j32;

    always_comb begin
        w_imm_i32 = $signed({{21{i_instr[31]}}, i_instr[30:20]});
        w_imm_s32 = $signed({{21{i_instr[31]}}, i_instr[30:25], i_instr[11:7]});
        w_imm_b32 = $signed({{20{i_instr[31]}}, i_instr[7], i_instr[30:25],
                             i_instr[11:8], 1'b0});
        w_imm_u32 = $signed({i_instr[31:12], 12'b0});
        w_imm_j32 = $signed({{12{i_instr[31]}}, i_instr[19:12], i_instr[20],
                             i_instr[30:21], 1'b0});
    end

    // Signed size casts carry the sign bit out to XLEN on wider datapaths.
    assign o_imm_i = XLEN'(w_imm_i32);
    assign o_imm_s = XLEN'(w_imm_s32);
    assign o_imm_b = XLEN'(w_imm_b32);
    assign o_imm_u = XLEN'(w_imm_u32);
    assign o_imm_j = XLEN'(w_imm_j32);

endmodule

// File: rtl/imm_decode_ctrl.sv
// ID-stage immediate controller: opcode decode, immediate select and a
// 2-entry skid buffer toward ID/EX. Define IMM_ILLEGAL_TRAP_EN to flag unknown opcodes.
module imm_decode_ctrl
    import imm_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int SEL_W = 3
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             FLUSH,
    input  logic             IF_VALID,
    output logic             IF_READY,
    input  logic [31:0]      INSTRUCTION,
    input  logic [XLEN-1:0]  PC,
    output logic             EX_VALID,
    input  logic             EX_READY,
    output logic [XLEN-1:0]  EX_IMM,
    output logic [SEL_W-1:0] EX_IMM_SEL,
    output logic [XLEN-1:0]  EX_PC,
    output logic             EX_ILLEGAL
);

    logic [XLEN-1:0] w_imm_i;
    logic [XLEN-1:0] w_imm_s;
    logic [XLEN-1:0] w_imm_b;
    logic [XLEN-1:0] w_imm_u;
    logic [XLEN-1:0] w_imm_j;

    imm_format_unit #(
        .XLEN (XLEN)
    ) u_fmt (
        .i_instr (INSTRUCTION),
        .o_imm_i (w_imm_i),
        .o_imm_s (w_imm_s),
        .o_imm_b (w_imm_b),
        .o_imm_u (w_imm_u),
        .o_imm_j (w_imm_j)
    );

    logic [6:0]      w_opcode;
    imm_sel_t        w_new_sel;
    logic [XLEN-1:0] w_new_imm;
    logic            w_new_ill;

    assign w_opcode = INSTRUCTION[6:0];

    always_comb begin
        w_new_sel = opcode_to_sel(w_opcode);
        w_new_imm = '0;
        case (w_new_sel)
            IMM_I:   w_new_imm = w_imm_i;
            IMM_S:   w_new_imm = w_imm_s;
            IMM_B:   w_new_imm = w_imm_b;
            IMM_U:   w_new_imm = w_imm_u;
            IMM_J:   w_new_imm = w_imm_j;
            default: w_new_imm = '0;
        endcase
`ifdef IMM_ILLEGAL_TRAP_EN
        w_new_ill = ~opcode_known(w_opcode);
`else
        w_new_ill = 1'b0;
`endif
    end

    occ_state_t r_state;
    occ_state_t w_next_state;
    logic       w_accept;
    logic       w_pop;
    logic       w_load_head_new;
    logic       w_load_skid;
    logic       w_head_from_skid;
    logic       w_clear;

    // Both handshake outputs decode the registered state only, so IF_READY
    // never has a combinational path from EX_READY.
    assign IF_READY = (r_state != OCC_FULL);
    assign EX_VALID = (r_state != OCC_EMPTY);
    assign w_accept = IF_VALID & IF_READY;
    assign w_pop    = EX_VALID & EX_READY;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state <= OCC_EMPTY;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state     = r_state;
        w_load_head_new  = 1'b0;
        w_load_skid      = 1'b0;
        w_head_from_skid = 1'b0;
        w_clear          = 1'b0;
        if (FLUSH) begin
            w_next_state = OCC_EMPTY;
            w_clear      = 1'b1;
        end else begin
            case (r_state)
                OCC_EMPTY: begin
                    if (w_accept) begin
                        w_next_state    = OCC_ONE;
                        w_load_head_new = 1'b1;
                    end
                end
                OCC_ONE: begin
                    if (w_accept && w_pop) begin
                        w_load_head_new = 1'b1;
                    end else if (w_accept) begin
                        w_next_state = OCC_FULL;
                        w_load_skid  = 1'b1;
                    end else if (w_pop) begin
                        w_next_state = OCC_EMPTY;
                    end
                end
                OCC_FULL: begin
                    if (w_pop) begin
                        w_next_state     = OCC_ONE;
                        w_head_from_skid = 1'b1;
                    end
                end
                default: begin
                    w_next_state = OCC_EMPTY;
                    w_clear      = 1'b1;
                end
            endcase
        end
    end

    logic [XLEN-1:0] r_head_imm;
    logic [2:0]      r_head_sel;
    logic [XLEN-1:0] r_head_pc;
    logic            r_head_ill;
    logic [XLEN-1:0] r_skid_imm;
    logic [2:0]      r_skid_sel;
    logic [XLEN-1:0] r_skid_pc;
    logic            r_skid_ill;

    // Head is the EX-facing register; it only changes on load, skid shift or clear.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_head_imm <= '0;
            r_head_sel <= '0;
            r_head_pc  <= '0;
            r_head_ill <= 1'b0;
        end else if (w_clear) begin
            r_head_imm <= '0;
            r_head_sel <= '0;
            r_head_pc  <= '0;
            r_head_ill <= 1'b0;
        end else if (w_load_head_new) begin
            r_head_imm <= w_new_imm;
            r_head_sel <= w_new_sel;
            r_head_pc  <= PC;
            r_head_ill <= w_new_ill;
        end else if (w_head_from_skid) begin
            r_head_imm <= r_skid_imm;
            r_head_sel <= r_skid_sel;
            r_head_pc  <= r_skid_pc;
            r_head_ill <= r_skid_ill;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_skid_imm <= '0;
            r_skid_sel <= '0;
            r_skid_pc  <= '0;
            r_skid_ill <= 1'b0;
        end else if (w_clear) begin
            r_skid_imm <= '0;
            r_skid_sel <= '0;
            r_skid_pc  <= '0;
            r_skid_ill <= 1'b0;
        end else if (w_load_skid) begin
            r_skid_imm <= w_new_imm;
            r_skid_sel <= w_new_sel;
            r_skid_pc  <= PC;
            r_skid_ill <= w_new_ill;
        end
    end

    assign EX_IMM     = r_head_imm;
    assign EX_IMM_SEL = SEL_W'(r_head_sel);
    assign EX_PC      = r_head_pc;
    assign EX_ILLEGAL = r_head_ill;

endmodule

// File: tb/tb_imm_decode_ctrl.sv
// Scoreboard bench for imm_decode_ctrl: expected entries are queued on accept
// and compared at the EX side every cycle.
module tb_imm_decode_ctrl;

`ifdef IMM_ILLEGAL_TRAP_EN
    localparam logic ILL_EXP = 1'b1;
`else
    localparam logic ILL_EXP = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        RESET;
    logic        FLUSH;
    logic        IF_VALID;
    logic        IF_READY;
    logic [31:0] INSTRUCTION;
    logic [31:0] PC;
    logic        EX_VALID;
    logic        EX_READY;
    logic [31:0] EX_IMM;
    logic [2:0]  EX_IMM_SEL;
    logic [31:0] EX_PC;
    logic        EX_ILLEGAL;

    imm_decode_ctrl #(
        .XLEN  (32),
        .SEL_W (3)
    ) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .FLUSH       (FLUSH),
        .IF_VALID    (IF_VALID),
        .IF_READY    (IF_READY),
        .INSTRUCTION (INSTRUCTION),
        .PC          (PC),
        .EX_VALID    (EX_VALID),
        .EX_READY    (EX_READY),
        .EX_IMM      (EX_IMM),
        .EX_IMM_SEL  (EX_IMM_SEL),
        .EX_PC       (EX_PC),
        .EX_ILLEGAL  (EX_ILLEGAL)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [31:0] imm;
        logic [2:0]  sel;
        logic [31:0] pc;
        logic        ill;
    } ent_t;

    ent_t        q[$];
    ent_t        e_new;
    logic        acc;
    logic [31:0] e_imm;
    logic [2:0]  e_sel;
    logic        e_ill;
    logic [31:0] pc_ctr;
    int          total = 0;
    int          bad   = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, act, exp);
        end
    endtask

    // Reference decode taken directly from the RV32I immediate definitions.
    task automatic model(input logic [31:0] i, output logic [31:0] imm,
                         output logic [2:0] sel, output logic ill);
        imm = 32'h0;
        sel = 3'd0;
        ill = 1'b0;
        case (i[6:0])
            7'b0110111, 7'b0010111: begin sel = 3'd4; imm = {i[31:12], 12'b0}; end
            7'b1101111: begin
                sel = 3'd5;
                imm = {{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0};
            end
            7'b1100111, 7'b0000011, 7'b0010011: begin
                sel = 3'd1;
                imm = {{21{i[31]}}, i[30:20]};
            end
            7'b0100011: begin sel = 3'd2; imm = {{21{i[31]}}, i[30:25], i[11:7]}; end
            7'b1100011: begin
                sel = 3'd3;
                imm = {{20{i[31]}}, i[7], i[30:25], i[11:8], 1'b0};
            end
            7'b0110011: sel = 3'd0;
            default:    ill = ILL_EXP;
        endcase
    endtask

    // EX-side monitor: occupancy, head contents and handshake tracking.
    always @(negedge CLK) begin
        if (RESET) begin
            q.delete();
        end else begin
            chk("ex_valid", 32'(EX_VALID), 32'(q.size() > 0));
            chk("if_ready", 32'(IF_READY), 32'(q.size() < 2));
            if (q.size() > 0) begin
                chk("ex_imm", EX_IMM, q[0].imm);
                chk("ex_sel", 32'(EX_IMM_SEL), 32'(q[0].sel));
                chk("ex_pc", EX_PC, q[0].pc);
                chk("ex_ill", 32'(EX_ILLEGAL), 32'(q[0].ill));
            end
            if (FLUSH) begin
                q.delete();
            end else begin
                acc = IF_VALID && (q.size() < 2);
                if (EX_READY && q.size() > 0) void'(q.pop_front());
                if (acc) begin
                    e_new.imm = e_imm;
                    e_new.sel = e_sel;
                    e_new.pc  = PC;
                    e_new.ill = e_ill;
                    q.push_back(e_new);
                end
            end
        end
    end

    task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] imm,
                         input logic [2:0] sel, input logic ill, input logic rdy);
        IF_VALID    = v;
        INSTRUCTION = ins;
        PC          = pc_ctr;
        e_imm       = imm;
        e_sel       = sel;
        e_ill       = ill;
        EX_READY    = rdy;
        @(posedge CLK);
        #1;
        pc_ctr = pc_ctr + 32'd4;
    endtask

    logic [31:0] tbl_ins [9] = '{32'h008000EF, 32'hFFFFF017, 32'h8000A083, 32'hFFFFFFFF,
                                 32'h00000033, 32'hFE000EE3, 32'h0020A423, 32'hFFC08067,
                                 32'hFE20AFA3};
    logic [31:0] tbl_imm [9] = '{32'h00000008, 32'hFFFFF000, 32'hFFFFF800, 32'h00000000,
                                 32'h00000000, 32'hFFFFFFFC, 32'h00000008, 32'hFFFFFFFC,
                                 32'hFFFFFFFF};
    logic [2:0]  tbl_sel [9] = '{3'd5, 3'd4, 3'd1, 3'd0, 3'd0, 3'd3, 3'd2, 3'd1, 3'd2};
    logic [6:0]  opcs   [11] = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b0000011,
                                 7'b0010011, 7'b0100011, 7'b1100011, 7'b0110011, 7'h7F,
                                 7'h0B};
    logic [31:0] rnd;
    logic [31:0] r_ins;
    logic [31:0] m_imm;
    logic [2:0]  m_sel;
    logic        m_ill;

    initial begin
        RESET = 1'b1; FLUSH = 1'b0; IF_VALID = 1'b0; EX_READY = 1'b0;
        INSTRUCTION = 32'h0; PC = 32'h0; pc_ctr = 32'h1000;
        e_imm = 32'h0; e_sel = 3'd0; e_ill = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_vld", 32'(EX_VALID), 32'd0);
        chk("rst_rdy", 32'(IF_READY), 32'd1);
        chk("rst_imm", EX_IMM, 32'h0);
        chk("rst_sel", 32'(EX_IMM_SEL), 32'd0);
        chk("rst_pc", EX_PC, 32'h0);
        chk("rst_ill", 32'(EX_ILLEGAL), 32'd0);
        RESET = 1'b0;

        drive(1'b1, 32'hFFF00093, 32'hFFFFFFFF, 3'd1, 1'b0, 1'b1);
        chk("addi_imm", EX_IMM, 32'hFFFFFFFF);
        chk("addi_sel", 32'(EX_IMM_SEL), 32'd1);
        drive(1'b0, 32'h0, 32'h0, 3'd0, 1'b0, 1'b1);

        drive(1'b1, 32'h12345037, 32'h12345000, 3'd4, 1'b0, 1'b1);
        chk("lui_imm", EX_IMM, 32'h12345000);
        drive(1'b1, 32'hFE000EE3, 32'hFFFFFFFC, 3'd3, 1'b0, 1'b1);
        chk("beq_imm", EX_IMM, 32'hFFFFFFFC);
        chk("beq_sel", 32'(EX_IMM_SEL), 32'd3);
        drive(1'b0, 32'h0, 32'h0, 3'd0, 1'b0, 1'b1);

        // Back-pressure: sw then add with EX stalled for three cycles.
        drive(1'b1, 32'h0020A423, 32'h00000008, 3'd2, 1'b0, 1'b0);
        chk("sw_rdy", 32'(IF_READY), 32'd1);
        drive(1'b1, 32'h00000033, 32'h00000000, 3'd0, 1'b0, 1'b0);
        chk("full_rdy", 32'(IF_READY), 32'd0);
        chk("sw_hold", EX_IMM, 32'h00000008);
        drive(1'b1, 32'h12345037, 32'h12345000, 3'd4, 1'b0, 1'b0);
        chk("sw_hold2", EX_IMM, 32'h00000008);
        chk("sw_sel", 32'(EX_IMM_SEL), 32'd2);
        drive(1'b0, 32'h0, 32'h0, 3'd0, 1'b0, 1'b1);
        chk("add_vld", 32'(EX_VALID), 32'd1);
        chk("add_sel", 32'(EX_IMM_SEL), 32'd0);
        chk("add_imm", EX_IMM, 32'h0);
        drive(1'b0, 32'h0, 32'h0, 3'd0, 1'b0, 1'b1);
        chk("drain_vld", 32'(EX_VALID), 32'd0);
        chk("drain_q", 32'(q.size()), 32'd0);

        // Flush while FULL wins over the accept and pop in the same cycle.
        drive(1'b1, 32'h12345037, 32'h12345000, 3'd4, 1'b0, 1'b0);
        drive(1'b1, 32'hFE000EE3, 32'hFFFFFFFC, 3'd3, 1'b0, 1'b0);
        chk("pre_fl_rdy", 32'(IF_READY), 32'd0);
        FLUSH = 1'b1;
        drive(1'b1, 32'hFFF00093, 32'hFFFFFFFF, 3'd1, 1'b0, 1'b1);
        FLUSH = 1'b0;
        chk("fl_vld", 32'(EX_VALID), 32'd0);
        chk("fl_rdy", 32'(IF_READY), 32'd1);
        chk("fl_imm", EX_IMM, 32'h0);
        chk("fl_sel", 32'(EX_IMM_SEL), 32'd0);
        chk("fl_pc", EX_PC, 32'h0);
        drive(1'b0, 32'h0, 32'h0, 3'd0, 1'b0, 1'b1);

        // Asynchronous reset mid-cycle while FULL.
        drive(1'b1, 32'h12345037, 32'h12345000, 3'd4, 1'b0, 1'b0);
        drive(1'b1, 32'hFE000EE3, 32'hFFFFFFFC, 3'd3, 1'b0, 1'b0);
        IF_VALID = 1'b0;
        #1;
        RESET = 1'b1;
        #1;
        chk("ar_vld", 32'(EX_VALID), 32'd0);
        chk("ar_imm", EX_IMM, 32'h0);
        chk("ar_rdy", 32'(IF_READY), 32'd1);
        chk("ar_pc", EX_PC, 32'h0);
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 3'd0, 1'b0, 1'b1);

        // Streaming table of formats, including an unknown opcode.
        for (int k = 0; k < 9; k++) begin
            drive(1'b1, tbl_ins[k], tbl_imm[k], tbl_sel[k],
                  (tbl_ins[k][6:0] == 7'h7F) ? ILL_EXP : 1'b0, 1'b1);
            chk("tbl_imm", EX_IMM, tbl_imm[k]);
            chk("tbl_sel", 32'(EX_IMM_SEL), 32'(tbl_sel[k]));
            if (tbl_ins[k][6:0] == 7'h7F)
                chk("ill_flag", 32'(EX_ILLEGAL), 32'(ILL_EXP));
        end
        drive(1'b0, 32'h0, 32'h0, 3'd0, 1'b0, 1'b1);

        // Random traffic with back-pressure and occasional flushes.
        for (int n = 0; n < 400; n++) begin
            rnd   = $urandom();
            r_ins = {rnd[31:7], opcs[$urandom_range(0, 10)]};
            model(r_ins, m_imm, m_sel, m_ill);
            FLUSH = ($urandom_range(0, 24) == 0);
            drive($urandom_range(0, 3) != 0, r_ins, m_imm, m_sel, m_ill,
                  $urandom_range(0, 2) != 0);
        end
        FLUSH = 1'b0;
        repeat (3) drive(1'b0, 32'h0, 32'h0, 3'd0, 1'b0, 1'b1);
        chk("final_q", 32'(q.size()), 32'd0);
        chk("final_vld", 32'(EX_VALID), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
